// File: rtl/game_session_ctrl.sv
// Session controller for the multi-game board: synchronizes switches and keys,
// debounces game selection, sequences game resets and gates key press pulses.
module game_session_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 50000,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [2:0] mode_sw,
    input  logic [2:0] key_n,
    output logic [2:0] active_mode,
    output logic       display_en,
    output logic       game_reset_n,
    output logic [2:0] key_pulse,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CLEAR,
        RUN
    } state_t;

    localparam logic [2:0]       MODE_BLANK = 3'b010;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Legal game codes are 000 and every odd code.
    function automatic logic mode_valid(input logic [2:0] m);
        return m[0] || (m == 3'b000);
    endfunction

    logic [2:0]       ms_meta, ms;
    logic [2:0]       ks_meta, ks, kprev;
    state_t           state, state_next;
    logic [2:0]       cand, cand_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       active_next;
    logic [2:0]       pulse_next;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next  = state;
        cand_next   = cand;
        cnt_next    = cnt;
        active_next = active_mode;
        pulse_next  = 3'b000;
        unique case (state)
            IDLE: begin
                if (mode_valid(ms)) begin
                    state_next = SETTLE;
                    cand_next  = ms;
                    cnt_next   = '0;
                end
            end
            SETTLE: begin
                if (ms != cand) begin
                    if (!mode_valid(ms)) begin
                        state_next = IDLE;
                    end else begin
                        cand_next = ms;
                        cnt_next  = '0;
                    end
                end else if (cnt == CNT_LAST) begin
                    active_next = cand;
                    cnt_next    = '0;
                    state_next  = CLEAR;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            CLEAR: begin
                // Mux select has already switched; games stay in reset two more cycles.
                if (cnt == CNT_ONE) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            RUN: begin
                if (ms != active_mode) begin
                    if (!mode_valid(ms)) begin
                        state_next = IDLE;
                    end else begin
                        state_next = SETTLE;
                        cand_next  = ms;
                        cnt_next   = '0;
                    end
                end else begin
                    pulse_next = kprev & ~ks;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            ms_meta      <= MODE_BLANK;
            ms           <= MODE_BLANK;
            ks_meta      <= 3'b111;
            ks           <= 3'b111;
            kprev        <= 3'b111;
            state        <= IDLE;
            cand         <= '0;
            cnt          <= '0;
            active_mode  <= MODE_BLANK;
            display_en   <= 1'b0;
            game_reset_n <= 1'b0;
            key_pulse    <= 3'b000;
            busy         <= 1'b1;
        end else begin
            ms_meta      <= mode_sw;
            ms           <= ms_meta;
            ks_meta      <= key_n;
            ks           <= ks_meta;
            kprev        <= ks;
            state        <= state_next;
            cand         <= cand_next;
            cnt          <= cnt_next;
            active_mode  <= active_next;
            display_en   <= (state_next == RUN);
            game_reset_n <= (state_next == RUN);
            key_pulse    <= pulse_next;
            busy         <= (state_next != RUN);
        end
    end

endmodule

// File: tb/tb_game_session_ctrl.sv
// Bench for game_session_ctrl: directed test-plan scenarios plus random stimulus,
// every cycle compared against a timestamp-based behavioural model.
module tb_game_session_ctrl;

    localparam int S = 4;

    localparam int P_IDLE   = 0;
    localparam int P_SETTLE = 1;
    localparam int P_CLEAR  = 2;
    localparam int P_RUN    = 3;

    logic       clk;
    logic       reset_n;
    logic [2:0] mode_sw;
    logic [2:0] key_n;
    logic [2:0] active_mode;
    logic       display_en;
    logic       game_reset_n;
    logic [2:0] key_pulse;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    game_session_ctrl #(.SETTLE_CYCLES(S), .CNT_W(16)) dut (
        .CLOCK_50    (clk),
        .reset_n     (reset_n),
        .mode_sw     (mode_sw),
        .key_n       (key_n),
        .active_mode (active_mode),
        .display_en  (display_en),
        .game_reset_n(game_reset_n),
        .key_pulse   (key_pulse),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: synchronizer pipelines plus a phase with timestamps.
    logic [2:0] m_ms_meta, m_ms, m_ks_meta, m_ks, m_kprev;
    logic [2:0] m_cand, m_active, m_pulse;
    int         m_phase, m_since, m_clear_end, now;

    function automatic bit legal_mode(input logic [2:0] m);
        return m inside {3'b000, 3'b001, 3'b011, 3'b101, 3'b111};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [2:0] ms_seen, ks_seen, prev;
        now++;
        if (!reset_n) begin
            m_ms_meta = 3'b010; m_ms = 3'b010;
            m_ks_meta = 3'b111; m_ks = 3'b111; m_kprev = 3'b111;
            m_cand = 3'b000; m_active = 3'b010; m_pulse = 3'b000;
            m_phase = P_IDLE;
        end else begin
            ms_seen = m_ms;
            ks_seen = m_ks;
            prev    = m_kprev;
            m_pulse = 3'b000;
            case (m_phase)
                P_IDLE: if (legal_mode(ms_seen)) begin
                    m_phase = P_SETTLE; m_cand = ms_seen; m_since = now;
                end
                P_SETTLE: begin
                    if (ms_seen != m_cand) begin
                        if (!legal_mode(ms_seen)) m_phase = P_IDLE;
                        else begin m_cand = ms_seen; m_since = now; end
                    end else if (now - m_since == S) begin
                        m_active = m_cand; m_phase = P_CLEAR; m_clear_end = now + 2;
                    end
                end
                P_CLEAR: if (now == m_clear_end) m_phase = P_RUN;
                default: begin
                    if (ms_seen != m_active) begin
                        if (!legal_mode(ms_seen)) m_phase = P_IDLE;
                        else begin m_phase = P_SETTLE; m_cand = ms_seen; m_since = now; end
                    end else begin
                        m_pulse = prev & ~ks_seen;
                    end
                end
            endcase
            m_ms      = m_ms_meta;
            m_ms_meta = mode_sw;
            m_kprev   = m_ks;
            m_ks      = m_ks_meta;
            m_ks_meta = key_n;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("active_mode", 32'(active_mode), 32'(m_active));
        check("display_en", 32'(display_en), 32'(m_phase == P_RUN));
        check("game_reset_n", 32'(game_reset_n), 32'(m_phase == P_RUN));
        check("busy", 32'(busy), 32'(m_phase != P_RUN));
        check("key_pulse", 32'(key_pulse), 32'(m_pulse));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_run(input int max_cycles);
        int n = 0;
        while (display_en !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        check("wait_run_timeout", 32'(display_en), 32'd1);
    endtask

    // Nine-cycle bring-up after reset release with mode m held.
    task automatic bringup_seq(input logic [2:0] m);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 6) check("bringup_pre_commit", 32'(active_mode), 32'h2);
            if (k == 7) check("bringup_commit", 32'(active_mode), 32'(m));
            if (k == 8) check("bringup_games_held", 32'(game_reset_n), 32'd0);
            if (k == 9) begin
                check("bringup_display", 32'(display_en), 32'd1);
                check("bringup_busy", 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        logic [2:0] legal_codes [5];
        int hold;
        now = 0;
        m_phase = P_IDLE;
        legal_codes = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b111};

        // 1: bring-up
        mode_sw = 3'b011; key_n = 3'b111; reset_n = 1'b0;
        ticks(2);
        reset_n = 1'b1;
        bringup_seq(3'b011);

        // 2: bouncing selection never commits early
        for (int i = 0; i < 6; i++) begin
            mode_sw = (i % 2 == 0) ? 3'b001 : 3'b011;
            ticks(2);
        end
        mode_sw = 3'b001;
        ticks(6);
        check("bounce_no_early_commit", 32'(active_mode), 32'h3);
        tick();
        check("bounce_commit", 32'(active_mode), 32'h1);
        wait_run(20);

        // 3: invalid code blanks display, keeps last commit
        mode_sw = 3'b110;
        ticks(3);
        check("invalid_display", 32'(display_en), 32'd0);
        check("invalid_reset", 32'(game_reset_n), 32'd0);
        check("invalid_busy", 32'(busy), 32'd1);
        check("invalid_keeps_mode", 32'(active_mode), 32'h1);
        ticks(3);
        mode_sw = 3'b101;
        wait_run(20);
        check("recover_mode", 32'(active_mode), 32'h5);

        // 4: key held through mode switch gives no pulse
        key_n = 3'b101; mode_sw = 3'b011;
        ticks(3);
        wait_run(20);
        ticks(4);
        check("held_key_no_pulse", 32'(key_pulse), 32'h0);
        key_n = 3'b111;
        ticks(3);
        key_n = 3'b101;
        ticks(2);
        check("repress_before", 32'(key_pulse), 32'h0);
        tick();
        check("repress_pulse", 32'(key_pulse), 32'h2);
        tick();
        check("repress_single", 32'(key_pulse), 32'h0);

        // 5: simultaneous keys, then key coincident with mode change
        key_n = 3'b111;
        ticks(3);
        key_n = 3'b001;
        ticks(3);
        check("multi_key_pulse", 32'(key_pulse), 32'h6);
        tick();
        check("multi_key_single", 32'(key_pulse), 32'h0);
        key_n = 3'b111;
        ticks(3);
        mode_sw = 3'b001; key_n = 3'b001;
        ticks(3);
        check("mode_wins_no_pulse", 32'(key_pulse), 32'h0);
        check("mode_wins_display", 32'(display_en), 32'd0);
        wait_run(20);
        key_n = 3'b111;
        ticks(3);

        // 6: reset pulse mid-SETTLE
        mode_sw = 3'b011;
        ticks(4);
        reset_n = 1'b0;
        tick();
        check("rst_active_mode", 32'(active_mode), 32'h2);
        check("rst_display", 32'(display_en), 32'd0);
        check("rst_game_reset", 32'(game_reset_n), 32'd0);
        check("rst_key_pulse", 32'(key_pulse), 32'h0);
        check("rst_busy", 32'(busy), 32'd1);
        reset_n = 1'b1;
        bringup_seq(3'b011);

        // Random phase against the model
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 9) < 7) mode_sw = legal_codes[$urandom_range(0, 4)];
                else mode_sw = 3'($urandom);
                hold = $urandom_range(1, 12);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 3) == 0) key_n = key_n ^ 3'($urandom);
            reset_n = ($urandom_range(0, 499) != 0);
            tick();
        end
        reset_n = 1'b1;
        ticks(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
